ex: RTL and testbench
=====================

Name: ex

Overview:
- Execute stage of the 5-stage MIPS32 pipeline.
- Consumes the decoded operation and operands that the decode stage produces, after they pass through the id_ex register.
- Produces the GPR write-back triple, which is also forwarded combinationally to decode, plus the HI/LO write request.
- Contains an iterative 32-cycle multiplier for MULT/MULTU/MUL, which stalls the front of the pipeline through stallreq_o.

Parameters:
- MUL_CYCLES, 32, iterations of the shift-add multiplier.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- aluop_i  in  8  ALU operation code.
- alusel_i  in  3  result class.
- reg1_i, reg2_i  in  32 each  operands (rs or immediate; rt or immediate).
- wd_i  in  5  destination GPR.
- wreg_i  in  1  GPR write enable.
- annul_i  in  1  flush; kills the current instruction.
- hi_i, lo_i  in  32 each  architectural HI/LO.
- mem_whilo_i  in  1  MEM stage writes HI/LO.
- mem_hi_i, mem_lo_i  in  32 each  MEM stage HI/LO data.
- wb_whilo_i  in  1  WB stage writes HI/LO.
- wb_hi_i, wb_lo_i  in  32 each  WB stage HI/LO data.
- wd_o  out  5  destination GPR.
- wreg_o  out  1  GPR write enable.
- wdata_o  out  32  GPR write data.
- whilo_o  out  1  HI/LO write enable.
- hi_o, lo_o  out  32 each  HI/LO write data.
- stallreq_o  out  1  stall request to the pipeline controller.

Behaviour:
- Reset (rst=0, async): multiplier state IDLE, counter/accumulators 0. All outputs are 0 while reset is asserted.
- Single-cycle ops are combinational, zero latency:
  - Logic: OR, AND, XOR, NOR.
  - Shift: SLL, SRL, SRA; reg2_i is shifted by reg1_i[4:0].
  - Arith: ADD/ADDU/ADDI/ADDIU/SUB/SUBU, SLT/SLTI (signed), SLTU/SLTIU (unsigned).
  - CLZ/CLO on reg1_i; result range 0..32.
  - Move: MOVZ/MOVN give wdata=reg1_i; wreg as decoded. MFHI/MFLO give the forwarded HI or LO.
- Overflow: ADD/ADDI/SUB signed overflow forces wreg_o=0 (no exception yet).
- HI/LO forwarding priority: mem_* over wb_* over hi_i/lo_i.
- MTHI: whilo_o=1, hi_o=reg1_i, lo_o=forwarded LO. MTLO is symmetric.
- wd_o always equals wd_i.
- annul_i=1: wreg_o=0 and whilo_o=0 that cycle.
- Multiplier FSM, states IDLE, RUN, DONE:
  - IDLE, mul-class aluop, annul_i=0, both operands nonzero: latch operand magnitudes (signed for MULT/MUL) and the result sign; counter=0; stallreq_o=1; go to RUN.
  - IDLE, either operand 0: go to DONE with product 0; stallreq_o=1 for this one cycle.
  - RUN: one partial-product bit per cycle; stallreq_o=1. After count==MUL_CYCLES-1, go to DONE.
  - DONE: stallreq_o=0. Product is negated if the signs differ.
    - MULT/MULTU: whilo_o=1, hi_o=product[63:32], lo_o=product[31:0].
    - MUL: wdata_o=product[31:0], wreg_o=1.
    - Next state IDLE.
- Normal latency: stallreq_o high for 33 cycles, result in the 34th.
- The controller holds inputs constant while stallreq_o=1.
- annul_i=1 in RUN or DONE: next state IDLE, stallreq_o=0 immediately, no writes.
- rst=0 mid-operation: state IDLE immediately, no writes.
- Back-to-back muls: DONE always passes through IDLE, so the same instruction never restarts.
- The next mul starts in the following IDLE cycle.

Optional Feature:
- Macro: EX_FAST_MUL_EN.
- Defined: single-cycle combinational 32x32 signed/unsigned product. FSM and counter are removed; stallreq_o is tied to 0. Results appear in the same cycle as the op.
- Undefined: the iterative FSM described above.

Decomposition:
- Shared defines.v gets:
  - DoubleRegBus 63:0.
  - MulIdle=2'b00, MulRun=2'b01, MulDone=2'b10.
  - MulCycles=32.
  - EXE_MULT_OP/EXE_MULTU_OP/EXE_MUL_OP, which are already present.
- Sub-module ex_mul, the iterative multiplier.
  - Inputs: clk, rst, start, signed, annul, opdata1, opdata2.
  - Outputs: result 64-bit, ready, busy.
  - The ALU/forwarding logic stays in ex.

Test Plan:
- MULT reg1=0xFFFFFFFE, reg2=0x00000003: stallreq_o high 33 cycles, then whilo_o=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA for one cycle.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF: hi_o=0xFFFFFFFE, lo_o=0x00000001. MUL 7 x 6: wdata_o=42, wreg_o=1.
- MULT with reg2=0: stallreq_o high 1 cycle, then hi_o=lo_o=0, whilo_o=1.
- MULT started, annul_i=1 at cycle 10: stallreq_o=0 same cycle, whilo_o=0. A following MULT 2x3 yields lo_o=6. Repeat with rst=0 at cycle 10: same idle outcome.
- ADD 0x7FFFFFFF+1: wreg_o=0. ADDU same: wdata_o=0x80000000, wreg_o=1. SLT 0xFFFFFFFF,1 gives 1; SLTU gives 0. CLZ 0x00010000 gives 15.
- MFHI with mem_whilo_i=1, mem_hi_i=0x1234, wb_whilo_i=1, wb_hi_i=0x5678: wdata_o=0x1234. With mem_whilo_i=0: 0x5678.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared types and opcode constants for the MIPS32 execute stage.
// Includes the wide HI/LO bus type, multiplier states and a leading-zero counter.
package ex_pkg;

    localparam int MulCycles = 32;

    typedef logic [63:0] double_reg_t;

    typedef enum logic [1:0] {
        MulIdle = 2'b00,
        MulRun  = 2'b01,
        MulDone = 2'b10
    } mul_state_e;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;
    localparam logic [2:0] EXE_RES_MUL   = 3'b101;

    localparam logic [7:0] EXE_NOP_OP   = 8'b00000000;
    localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;
    localparam logic [7:0] EXE_MOVZ_OP  = 8'b00001010;
    localparam logic [7:0] EXE_MOVN_OP  = 8'b00001011;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
    localparam logic [7:0] EXE_SLT_OP   = 8'b00101010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b00101011;
    localparam logic [7:0] EXE_SLTI_OP  = 8'b01010111;
    localparam logic [7:0] EXE_SLTIU_OP = 8'b01011000;
    localparam logic [7:0] EXE_ADD_OP   = 8'b00100000;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b00100001;
    localparam logic [7:0] EXE_SUB_OP   = 8'b00100010;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b00100011;
    localparam logic [7:0] EXE_ADDI_OP  = 8'b01010101;
    localparam logic [7:0] EXE_ADDIU_OP = 8'b01010110;
    localparam logic [7:0] EXE_CLZ_OP   = 8'b10110000;
    localparam logic [7:0] EXE_CLO_OP   = 8'b10110001;
    localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
    localparam logic [7:0] EXE_MUL_OP   = 8'b10101001;

    // Scans upward so the highest set bit wins; an all-zero word yields 32.
    function automatic logic [5:0] clz32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n = 6'(31 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/ex_if.sv
// id_ex -> EX operation/operand bundle and EX -> ex_mem/ctrl result bundle.
// The master side is the pipeline (register + controller); the slave side is ex.
interface ex_if;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        annul_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        mem_whilo_i;
    logic [31:0] mem_hi_i;
    logic [31:0] mem_lo_i;
    logic        wb_whilo_i;
    logic [31:0] wb_hi_i;
    logic [31:0] wb_lo_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, annul_i,
               hi_i, lo_i, mem_whilo_i, mem_hi_i, mem_lo_i,
               wb_whilo_i, wb_hi_i, wb_lo_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, annul_i,
               hi_i, lo_i, mem_whilo_i, mem_hi_i, mem_lo_i,
               wb_whilo_i, wb_hi_i, wb_lo_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );
endinterface

// File: rtl/ex_mul.sv
// Iterative shift-add 32x32 multiplier: one partial product per cycle on magnitudes,
// sign applied at the end. A zero operand skips straight to the result state.
module ex_mul
    import ex_pkg::*;
#(
    parameter int MUL_CYCLES = MulCycles
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic        annul_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output double_reg_t result_o,
    output logic        ready_o,
    output logic        busy_o
);

    localparam int CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    mul_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    double_reg_t     acc_q, acc_d;
    double_reg_t     mcand_q, mcand_d;
    logic [31:0]     mplier_q, mplier_d;
    logic            neg_q, neg_d;
    logic [31:0]     mag1, mag2;

    assign mag1 = (signed_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    assign mag2 = (signed_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= MulIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        busy_o   = 1'b0;
        ready_o  = 1'b0;
        case (state_q)
            MulIdle: begin
                if (start_i && !annul_i) begin
                    busy_o = 1'b1;
                    acc_d  = '0;
                    cnt_d  = '0;
                    if (opdata1_i == 32'd0 || opdata2_i == 32'd0) begin
                        neg_d   = 1'b0;
                        state_d = MulDone;
                    end else begin
                        mcand_d  = {32'd0, mag1};
                        mplier_d = mag2;
                        neg_d    = signed_i & (opdata1_i[31] ^ opdata2_i[31]);
                        state_d  = MulRun;
                    end
                end
            end
            MulRun: begin
                if (annul_i) begin
                    state_d = MulIdle;
                end else begin
                    busy_o   = 1'b1;
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CntW'(MUL_CYCLES - 1)) state_d = MulDone;
                end
            end
            MulDone: begin
                ready_o = !annul_i;
                state_d = MulIdle;
            end
            default: state_d = MulIdle;
        endcase
    end

    assign result_o = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/ex.sv
// MIPS32 execute stage: ALU, HI/LO forwarding and multiplier control.
// Define EX_FAST_MUL_EN for a single-cycle combinational multiplier instead of ex_mul.
module ex
    import ex_pkg::*;
#(
    parameter int MUL_CYCLES = MulCycles
) (
    input logic clk,
    input logic rst,
    ex_if.slave bus
);

    logic [31:0]       r1, r2, hi_fwd, lo_fwd;
    logic signed [31:0] r1s, r2s;
    logic signed [32:0] a33, b33, s33;
    logic [7:0]        op;
    logic              is_sub, ov, slt, sltu;
    logic              is_mul, mul_signed, mul_start, mul_ready, mul_busy;
    double_reg_t       mul_prod;

    assign op  = bus.aluop_i;
    assign r1  = bus.reg1_i;
    assign r2  = bus.reg2_i;
    assign r1s = bus.reg1_i;
    assign r2s = bus.reg2_i;

    always_comb begin
        if (bus.mem_whilo_i) begin
            hi_fwd = bus.mem_hi_i;
            lo_fwd = bus.mem_lo_i;
        end else if (bus.wb_whilo_i) begin
            hi_fwd = bus.wb_hi_i;
            lo_fwd = bus.wb_lo_i;
        end else begin
            hi_fwd = bus.hi_i;
            lo_fwd = bus.lo_i;
        end
    end

    // 33-bit sign-extended sum: overflow shows up as bit 32 disagreeing with bit 31.
    assign is_sub = (op == EXE_SUB_OP) || (op == EXE_SUBU_OP);
    assign a33    = {r1s[31], r1s};
    assign b33    = {r2s[31], r2s};
    assign s33    = is_sub ? (a33 - b33) : (a33 + b33);
    assign ov     = ((op == EXE_ADD_OP) || (op == EXE_ADDI_OP) || (op == EXE_SUB_OP))
                    && (s33[32] != s33[31]);
    assign slt    = r1s < r2s;
    assign sltu   = r1 < r2;

    assign is_mul     = (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) || (op == EXE_MUL_OP);
    assign mul_signed = (op != EXE_MULTU_OP);
    assign mul_start  = is_mul & ~bus.annul_i;

`ifdef EX_FAST_MUL_EN
    assign mul_prod  = {{32{mul_signed & r1[31]}}, r1} * {{32{mul_signed & r2[31]}}, r2};
    assign mul_ready = mul_start;
    assign mul_busy  = 1'b0;
`else
    ex_mul #(
        .MUL_CYCLES(MUL_CYCLES)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .signed_i  (mul_signed),
        .annul_i   (bus.annul_i),
        .opdata1_i (r1),
        .opdata2_i (r2),
        .result_o  (mul_prod),
        .ready_o   (mul_ready),
        .busy_o    (mul_busy)
    );
`endif

    logic [4:0]  wd;
    logic        wreg, whilo, stall;
    logic [31:0] wdata, hi_w, lo_w;

    always_comb begin
        wd    = bus.wd_i;
        wreg  = bus.wreg_i & ~ov & ~bus.annul_i;
        wdata = 32'd0;
        whilo = 1'b0;
        hi_w  = 32'd0;
        lo_w  = 32'd0;
        stall = mul_busy;
        case (bus.alusel_i)
            EXE_RES_LOGIC: begin
                case (op)
                    EXE_AND_OP: wdata = r1 & r2;
                    EXE_OR_OP:  wdata = r1 | r2;
                    EXE_XOR_OP: wdata = r1 ^ r2;
                    EXE_NOR_OP: wdata = ~(r1 | r2);
                    default:    wdata = 32'd0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (op)
                    EXE_SLL_OP: wdata = r2 << r1[4:0];
                    EXE_SRL_OP: wdata = r2 >> r1[4:0];
                    EXE_SRA_OP: wdata = r2s >>> r1[4:0];
                    default:    wdata = 32'd0;
                endcase
            end
            EXE_RES_ARITH: begin
                case (op)
                    EXE_SLT_OP, EXE_SLTI_OP:   wdata = {31'd0, slt};
                    EXE_SLTU_OP, EXE_SLTIU_OP: wdata = {31'd0, sltu};
                    EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP,
                    EXE_SUB_OP, EXE_SUBU_OP:   wdata = s33[31:0];
                    EXE_CLZ_OP:                wdata = {26'd0, clz32(r1)};
                    EXE_CLO_OP:                wdata = {26'd0, clz32(~r1)};
                    default:                   wdata = 32'd0;
                endcase
            end
            EXE_RES_MOVE: begin
                case (op)
                    EXE_MFHI_OP:              wdata = hi_fwd;
                    EXE_MFLO_OP:              wdata = lo_fwd;
                    EXE_MOVZ_OP, EXE_MOVN_OP: wdata = r1;
                    default:                  wdata = 32'd0;
                endcase
            end
            EXE_RES_MUL: wdata = mul_prod[31:0];
            default:     wdata = 32'd0;
        endcase

        case (op)
            EXE_MTHI_OP: begin
                whilo = 1'b1;
                hi_w  = r1;
                lo_w  = lo_fwd;
            end
            EXE_MTLO_OP: begin
                whilo = 1'b1;
                hi_w  = hi_fwd;
                lo_w  = r1;
            end
            EXE_MULT_OP, EXE_MULTU_OP: begin
                whilo = mul_ready;
                hi_w  = mul_prod[63:32];
                lo_w  = mul_prod[31:0];
            end
            EXE_MUL_OP: wreg = mul_ready;
            default: ;
        endcase

        if (bus.annul_i) begin
            wreg  = 1'b0;
            whilo = 1'b0;
        end

        if (!rst) begin
            wd    = 5'd0;
            wreg  = 1'b0;
            wdata = 32'd0;
            whilo = 1'b0;
            hi_w  = 32'd0;
            lo_w  = 32'd0;
            stall = 1'b0;
        end
    end

    assign bus.wd_o       = wd;
    assign bus.wreg_o     = wreg;
    assign bus.wdata_o    = wdata;
    assign bus.whilo_o    = whilo;
    assign bus.hi_o       = hi_w;
    assign bus.lo_o       = lo_w;
    assign bus.stallreq_o = stall;

endmodule

// File: tb/tb_ex.sv
// Directed testbench for the ex execute stage: ALU ops, HI/LO forwarding,
// iterative multiply latency, annul/reset abort and back-to-back multiplies.
module tb_ex;
    import ex_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ex_if bus ();

    ex #(.MUL_CYCLES(MulCycles)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic clear_hilo();
        bus.hi_i = 32'd0;        bus.lo_i = 32'd0;
        bus.mem_whilo_i = 1'b0;  bus.mem_hi_i = 32'd0; bus.mem_lo_i = 32'd0;
        bus.wb_whilo_i = 1'b0;   bus.wb_hi_i = 32'd0;  bus.wb_lo_i = 32'd0;
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wd, input logic wr);
        bus.aluop_i = op;  bus.alusel_i = sel;
        bus.reg1_i = a;    bus.reg2_i = b;
        bus.wd_i = wd;     bus.wreg_i = wr;
        bus.annul_i = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Counts stall cycles until stallreq_o drops; leaves time in the result cycle.
    task automatic run_mul(output int stalls);
        stalls = 0;
        #1;
        while (bus.stallreq_o === 1'b1 && stalls < 40) begin
            stalls++;
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_hilo();
        drive(EXE_ADDU_OP, EXE_RES_ARITH, 32'd5, 32'd3, 5'd9, 1'b1);
        #2;
        n_tests++; if (bus.wreg_o !== 1'b0) begin n_fail++; $display("FAIL rst_wreg got %0h exp 0", bus.wreg_o); end
        n_tests++; if (bus.wdata_o !== 32'd0) begin n_fail++; $display("FAIL rst_wdata got %0h exp 0", bus.wdata_o); end
        n_tests++; if (bus.wd_o !== 5'd0) begin n_fail++; $display("FAIL rst_wd got %0h exp 0", bus.wd_o); end
        drive(EXE_MULT_OP, EXE_RES_NOP, 32'd5, 32'd7, 5'd0, 1'b0);
        #1;
        n_tests++; if (bus.stallreq_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %0h exp 0", bus.stallreq_o); end
        next_cycle();
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_alu();
        next_cycle();
        drive(EXE_ADD_OP, EXE_RES_ARITH, 32'h7FFFFFFF, 32'd1, 5'd4, 1'b1);
        #1;
        n_tests++; if (bus.wreg_o !== 1'b0) begin n_fail++; $display("FAIL add_ovf_wreg got %0h exp 0", bus.wreg_o); end
        n_tests++; if (bus.wd_o !== 5'd4) begin n_fail++; $display("FAIL add_wd got %0h exp 4", bus.wd_o); end
        drive(EXE_ADDU_OP, EXE_RES_ARITH, 32'h7FFFFFFF, 32'd1, 5'd4, 1'b1);
        #1;
        n_tests++; if (bus.wdata_o !== 32'h80000000) begin n_fail++; $display("FAIL addu_data got %0h exp 80000000", bus.wdata_o); end
        n_tests++; if (bus.wreg_o !== 1'b1) begin n_fail++; $display("FAIL addu_wreg got %0h exp 1", bus.wreg_o); end
        drive(EXE_SUB_OP, EXE_RES_ARITH, 32'd0, 32'h80000000, 5'd4, 1'b1);
        #1;
        n_tests++; if (bus.wreg_o !== 1'b0) begin n_fail++; $display("FAIL sub_ovf_wreg got %0h exp 0", bus.wreg_o); end
        drive(EXE_SUBU_OP, EXE_RES_ARITH, 32'd10, 32'd12, 5'd4, 1'b1);
        #1;
        n_tests++; if (bus.wdata_o !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL subu_data got %0h exp fffffffe", bus.wdata_o); end
        drive(EXE_SLT_OP, EXE_RES_ARITH, 32'hFFFFFFFF, 32'd1, 5'd4, 1'b1);
        #1;
        n_tests++; if (bus.wdata_o !== 32'd1) begin n_fail++; $display("FAIL slt got %0h exp 1", bus.wdata_o); end
        drive(EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFFFFFF, 32'd1, 5'd4, 1'b1);
        #1;
        n_tests++; if (bus.wdata_o !== 32'd0) begin n_fail++; $display("FAIL sltu got %0h exp 0", bus.wdata_o); end
        drive(EXE_CLZ_OP, EXE_RES_ARITH, 32'h00010000, 32'd0, 5'd4, 1'b1);
        #1;
        n_tests++; if (bus.wdata_o !== 32'd15) begin n_fail++; $display("FAIL clz got %0d exp 15", bus.wdata_o); end
        drive(EXE_CLZ_OP, EXE_RES_ARITH, 32'd0, 32'd0, 5'd4, 1'b1);
        #1;
        n_tests++; if (bus.wdata_o !== 32'd32) begin n_fail++; $display("FAIL clz_zero got %0d exp 32", bus.wdata_o); end
        drive(EXE_CLO_OP, EXE_RES_ARITH, 32'hFFF00000, 32'd0, 5'd4, 1'b1);
        #1;
        n_tests++; if (bus.wdata_o !== 32'd12) begin n_fail++; $display("FAIL clo got %0d exp 12", bus.wdata_o); end
        drive(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h80000000, 5'd4, 1'b1);
        #1;
        n_tests++; if (bus.wdata_o !== 32'hF8000000) begin n_fail++; $display("FAIL sra got %0h exp f8000000", bus.wdata_o); end
        drive(EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h80000000, 5'd4, 1'b1);
        #1;
        n_tests++; if (bus.wdata_o !== 32'h08000000) begin n_fail++; $display("FAIL srl got %0h exp 08000000", bus.wdata_o); end
        drive(EXE_SLL_OP, EXE_RES_SHIFT, 32'd31, 32'd1, 5'd4, 1'b1);
        #1;
        n_tests++; if (bus.wdata_o !== 32'h80000000) begin n_fail++; $display("FAIL sll got %0h exp 80000000", bus.wdata_o); end
        drive(EXE_NOR_OP, EXE_RES_LOGIC, 32'h0000FF00, 32'h000000F0, 5'd4, 1'b1);
        #1;
        n_tests++; if (bus.wdata_o !== 32'hFFFF000F) begin n_fail++; $display("FAIL nor got %0h exp ffff000f", bus.wdata_o); end
        drive(EXE_XOR_OP, EXE_RES_LOGIC, 32'hF0F0F0F0, 32'hFF00FF00, 5'd4, 1'b1);
        #1;
        n_tests++; if (bus.wdata_o !== 32'h0FF00FF0) begin n_fail++; $display("FAIL xor got %0h exp 0ff00ff0", bus.wdata_o); end
        drive(EXE_MOVN_OP, EXE_RES_MOVE, 32'hCAFEF00D, 32'd1, 5'd7, 1'b1);
        #1;
        n_tests++; if (bus.wdata_o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL movn got %0h exp cafef00d", bus.wdata_o); end
        drive(EXE_ADDU_OP, EXE_RES_ARITH, 32'd1, 32'd2, 5'd4, 1'b1);
        bus.annul_i = 1'b1;
        #1;
        n_tests++; if (bus.wreg_o !== 1'b0) begin n_fail++; $display("FAIL annul_wreg got %0h exp 0", bus.wreg_o); end
        bus.annul_i = 1'b0;
    endtask

    task automatic test_hilo_fwd();
        next_cycle();
        clear_hilo();
        bus.hi_i = 32'h1111;
        bus.lo_i = 32'hAAAA;
        bus.mem_whilo_i = 1'b1; bus.mem_hi_i = 32'h1234;
        bus.wb_whilo_i = 1'b1;  bus.wb_hi_i = 32'h5678; bus.wb_lo_i = 32'h9999;
        drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd2, 1'b1);
        #1;
        n_tests++; if (bus.wdata_o !== 32'h1234) begin n_fail++; $display("FAIL mfhi_mem got %0h exp 1234", bus.wdata_o); end
        bus.mem_whilo_i = 1'b0;
        #1;
        n_tests++; if (bus.wdata_o !== 32'h5678) begin n_fail++; $display("FAIL mfhi_wb got %0h exp 5678", bus.wdata_o); end
        bus.wb_whilo_i = 1'b0;
        drive(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd2, 1'b1);
        #1;
        n_tests++; if (bus.wdata_o !== 32'hAAAA) begin n_fail++; $display("FAIL mflo_arch got %0h exp aaaa", bus.wdata_o); end
        bus.wb_whilo_i = 1'b1;
        drive(EXE_MTHI_OP, EXE_RES_NOP, 32'hDEAD, 32'd0, 5'd0, 1'b0);
        #1;
        n_tests++; if (bus.whilo_o !== 1'b1) begin n_fail++; $display("FAIL mthi_whilo got %0h exp 1", bus.whilo_o); end
        n_tests++; if (bus.hi_o !== 32'hDEAD) begin n_fail++; $display("FAIL mthi_hi got %0h exp dead", bus.hi_o); end
        n_tests++; if (bus.lo_o !== 32'h9999) begin n_fail++; $display("FAIL mthi_lo got %0h exp 9999", bus.lo_o); end
        clear_hilo();
    endtask

    task automatic test_mult();
        int stalls;
        next_cycle();
        drive(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFFFFFE, 32'h00000003, 5'd0, 1'b0);
        run_mul(stalls);
        n_tests++; if (stalls != 33) begin n_fail++; $display("FAIL mult_stalls got %0d exp 33", stalls); end
        n_tests++; if (bus.whilo_o !== 1'b1) begin n_fail++; $display("FAIL mult_whilo got %0h exp 1", bus.whilo_o); end
        n_tests++; if (bus.hi_o !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi got %0h exp ffffffff", bus.hi_o); end
        n_tests++; if (bus.lo_o !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mult_lo got %0h exp fffffffa", bus.lo_o); end
        next_cycle();
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        #1;
        n_tests++; if (bus.whilo_o !== 1'b0) begin n_fail++; $display("FAIL mult_after_whilo got %0h exp 0", bus.whilo_o); end

        next_cycle();
        drive(EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b0);
        run_mul(stalls);
        n_tests++; if (stalls != 33) begin n_fail++; $display("FAIL multu_stalls got %0d exp 33", stalls); end
        n_tests++; if (bus.hi_o !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi got %0h exp fffffffe", bus.hi_o); end
        n_tests++; if (bus.lo_o !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo got %0h exp 1", bus.lo_o); end

        next_cycle();
        drive(EXE_MUL_OP, EXE_RES_MUL, 32'd7, 32'd6, 5'd12, 1'b1);
        #1;
        n_tests++; if (bus.wreg_o !== 1'b0) begin n_fail++; $display("FAIL mul_wreg_busy got %0h exp 0", bus.wreg_o); end
        run_mul(stalls);
        n_tests++; if (bus.wdata_o !== 32'd42) begin n_fail++; $display("FAIL mul_data got %0d exp 42", bus.wdata_o); end
        n_tests++; if (bus.wreg_o !== 1'b1) begin n_fail++; $display("FAIL mul_wreg got %0h exp 1", bus.wreg_o); end
        n_tests++; if (bus.wd_o !== 5'd12) begin n_fail++; $display("FAIL mul_wd got %0d exp 12", bus.wd_o); end

        next_cycle();
        drive(EXE_MULT_OP, EXE_RES_NOP, 32'h12345678, 32'd0, 5'd0, 1'b0);
        run_mul(stalls);
        n_tests++; if (stalls != 1) begin n_fail++; $display("FAIL mult_zero_stalls got %0d exp 1", stalls); end
        n_tests++; if (bus.whilo_o !== 1'b1) begin n_fail++; $display("FAIL mult_zero_whilo got %0h exp 1", bus.whilo_o); end
        n_tests++; if ({bus.hi_o, bus.lo_o} !== 64'd0) begin n_fail++; $display("FAIL mult_zero_prod got %0h exp 0", {bus.hi_o, bus.lo_o}); end
        next_cycle();
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    task automatic test_abort();
        int stalls;
        next_cycle();
        drive(EXE_MULT_OP, EXE_RES_NOP, 32'd5, 32'd7, 5'd0, 1'b0);
        for (int i = 0; i < 10; i++) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        #1;
        n_tests++; if (bus.stallreq_o !== 1'b0) begin n_fail++; $display("FAIL annul_stall got %0h exp 0", bus.stallreq_o); end
        n_tests++; if (bus.whilo_o !== 1'b0) begin n_fail++; $display("FAIL annul_whilo got %0h exp 0", bus.whilo_o); end
        next_cycle();
        drive(EXE_MULT_OP, EXE_RES_NOP, 32'd2, 32'd3, 5'd0, 1'b0);
        run_mul(stalls);
        n_tests++; if (stalls != 33) begin n_fail++; $display("FAIL post_annul_stalls got %0d exp 33", stalls); end
        n_tests++; if (bus.lo_o !== 32'd6 || bus.hi_o !== 32'd0) begin n_fail++; $display("FAIL post_annul_prod got %0h_%0h exp 0_6", bus.hi_o, bus.lo_o); end

        next_cycle();
        drive(EXE_MULT_OP, EXE_RES_NOP, 32'd5, 32'd7, 5'd0, 1'b0);
        for (int i = 0; i < 10; i++) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_tests++; if (bus.stallreq_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall got %0h exp 0", bus.stallreq_o); end
        n_tests++; if (bus.whilo_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_whilo got %0h exp 0", bus.whilo_o); end
        next_cycle();
        rst = 1'b1;
        drive(EXE_MULT_OP, EXE_RES_NOP, 32'd2, 32'd3, 5'd0, 1'b0);
        run_mul(stalls);
        n_tests++; if (stalls != 33) begin n_fail++; $display("FAIL post_rst_stalls got %0d exp 33", stalls); end
        n_tests++; if (bus.lo_o !== 32'd6 || bus.whilo_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_prod got lo=%0h whilo=%0h exp lo=6 whilo=1", bus.lo_o, bus.whilo_o); end
    endtask

    task automatic test_back_to_back();
        int stalls;
        next_cycle();
        drive(EXE_MULTU_OP, EXE_RES_NOP, 32'd3, 32'd4, 5'd0, 1'b0);
        run_mul(stalls);
        n_tests++; if (bus.lo_o !== 32'd12 || stalls != 33) begin n_fail++; $display("FAIL b2b_first got lo=%0d stalls=%0d exp lo=12 stalls=33", bus.lo_o, stalls); end
        next_cycle();
        drive(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFFFFFB, 32'd6, 5'd0, 1'b0);
        run_mul(stalls);
        n_tests++; if (stalls != 33) begin n_fail++; $display("FAIL b2b_second_stalls got %0d exp 33", stalls); end
        n_tests++; if ({bus.hi_o, bus.lo_o} !== 64'hFFFFFFFF_FFFFFFE2) begin n_fail++; $display("FAIL b2b_second_prod got %0h exp ffffffffffffffe2", {bus.hi_o, bus.lo_o}); end
        next_cycle();
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_hilo_fwd();
        test_mult();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
